// File: rtl/inst_fetcher_if.sv
// rtl/inst_fetcher_if.sv - instruction memory read bus between fetcher and memory
//
// Signals:
//   mem_req    fetcher -> memory  read request
//   mem_addr   fetcher -> memory  30-bit word address
//   mem_ack    memory -> fetcher  read data valid (meaningful only while mem_req is high)
//   mem_rdata  memory -> fetcher  32-bit read data
//
// Modports: master = fetcher side, slave = memory side.

interface inst_fetcher_if;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - single-instruction fetcher with one-entry last-fetch buffer and request timeout/retry
//
// Parameters:
//   TIMEOUT_CYCLES     REQ cycles without ack before the request is dropped and reissued (2..255)
// Ports:
//   clk                clock, rising edge
//   reset              synchronous active-high reset
//   fetcher_reset      high = hold idle / abort; low = fetch the instruction at pc
//   pc                 byte address of the instruction, bits [1:0] ignored
//   fetcher_completed  instruction is valid for the current fetch
//   instruction        fetched instruction word, held while fetcher_reset is high
//   cache_inv          one-cycle pulse, invalidates the last-fetch buffer
//   mem                instruction memory read bus (master side)
//   timeout_count      saturating count of timed-out requests since reset

module inst_fetcher #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetcher_reset,
    input  logic [31:0]           pc,
    output logic                  fetcher_completed,
    output logic [31:0]           instruction,
    input  logic                  cache_inv,
    inst_fetcher_if.master        mem,
    output logic [7:0]            timeout_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] RETRY = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state;
    logic [29:0] addr_q;
    logic [7:0]  wait_cnt;
    logic        buf_valid;
    logic [29:0] buf_tag;
    logic [31:0] buf_data;

    // Outputs decode straight from state, so reset and abort clear them at the same edge.
    assign fetcher_completed = (state == DONE);
    assign mem.mem_req       = (state == REQ);
    assign mem.mem_addr      = addr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= '0;
            wait_cnt      <= '0;
            instruction   <= '0;
            buf_valid     <= 1'b0;
            buf_tag       <= '0;
            buf_data      <= '0;
            timeout_count <= '0;
        end else begin
            if (fetcher_reset) begin
                // Abort: any data arriving now is dropped, only the state moves.
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        addr_q <= pc[31:2];
                        // A same-cycle invalidate forces the lookup to miss.
                        if (buf_valid && !cache_inv && (buf_tag == pc[31:2])) begin
                            instruction <= buf_data;
                            state       <= DONE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= REQ;
                        end
                    end
                    REQ: begin
                        if (mem.mem_ack) begin
                            instruction <= mem.mem_rdata;
                            buf_data    <= mem.mem_rdata;
                            buf_tag     <= addr_q;
                            buf_valid   <= 1'b1;
                            state       <= DONE;
                        end else if (wait_cnt == WAIT_LAST) begin
                            if (timeout_count != 8'hFF)
                                timeout_count <= timeout_count + 8'd1;
                            state <= RETRY;
                        end else begin
                            wait_cnt <= wait_cnt + 8'd1;
                        end
                    end
                    RETRY: begin
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                    default: begin
                        // DONE: hold until fetcher_reset; pc is not looked at here.
                        state <= DONE;
                    end
                endcase
            end

            // Placed last so an invalidate coinciding with a fill wins over buf_valid <= 1.
            if (cache_inv)
                buf_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - directed self-checking bench for inst_fetcher

module tb_inst_fetcher;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetcher_reset;
    logic [31:0] pc;
    logic        fetcher_completed;
    logic [31:0] instruction;
    logic        cache_inv;
    logic [7:0]  timeout_count;

    int vectors = 0;
    int errors  = 0;

    inst_fetcher_if mem ();

    inst_fetcher #(.TIMEOUT_CYCLES(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .fetcher_reset     (fetcher_reset),
        .pc                (pc),
        .fetcher_completed (fetcher_completed),
        .instruction       (instruction),
        .cache_inv         (cache_inv),
        .mem               (mem.master),
        .timeout_count     (timeout_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        fetcher_reset = 1'b1;
        pc            = 32'h0;
        cache_inv     = 1'b0;
        mem.mem_ack   = 1'b0;
        mem.mem_rdata = 32'h0;

        // Reset state
        step();
        step();
        check("rst_completed", 32'(fetcher_completed), 32'h0);
        check("rst_mem_req",   32'(mem.mem_req),       32'h0);
        check("rst_instr",     instruction,            32'h0);
        check("rst_timeouts",  32'(timeout_count),     32'h0);
        check("rst_mem_addr",  32'(mem.mem_addr),      32'h0);
        reset = 1'b0;
        step();

        // Miss at 0x100, acked in the first REQ cycle
        fetcher_reset = 1'b0;
        pc            = 32'h100;
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'h2002_0005;
        step();
        check("miss_req",       32'(mem.mem_req),       32'h1);
        check("miss_addr",      32'(mem.mem_addr),      32'h40);
        check("miss_not_done",  32'(fetcher_completed), 32'h0);
        step();
        check("miss_done",      32'(fetcher_completed), 32'h1);
        check("miss_instr",     instruction,            32'h2002_0005);
        check("miss_req_low",   32'(mem.mem_req),       32'h0);
        mem.mem_ack = 1'b0;

        // Hit: fetcher_reset pulse, same pc
        fetcher_reset = 1'b1;
        step();
        check("hit_idle_done",  32'(fetcher_completed), 32'h0);
        check("hit_idle_req",   32'(mem.mem_req),       32'h0);
        fetcher_reset = 1'b0;
        step();
        check("hit_done",       32'(fetcher_completed), 32'h1);
        check("hit_no_req",     32'(mem.mem_req),       32'h0);
        check("hit_instr",      instruction,            32'h2002_0005);

        // Hold with fetcher_reset high and pc changed
        fetcher_reset = 1'b1;
        pc            = 32'h200;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_done",  32'(fetcher_completed), 32'h0);
            check("hold_instr", instruction,            32'h2002_0005);
            check("hold_req",   32'(mem.mem_req),       32'h0);
        end

        // Invalidate: re-establish hit on 0x100, pulse cache_inv, fetch again
        pc            = 32'h100;
        fetcher_reset = 1'b0;
        step();
        check("inv_prehit",     32'(fetcher_completed), 32'h1);
        check("inv_prehit_req", 32'(mem.mem_req),       32'h0);
        fetcher_reset = 1'b1;
        cache_inv     = 1'b1;
        step();
        cache_inv = 1'b0;
        step();
        fetcher_reset = 1'b0;
        step();
        check("inv_miss_req",   32'(mem.mem_req),       32'h1);
        check("inv_miss_addr",  32'(mem.mem_addr),      32'h40);
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'h2002_0005;
        step();
        check("inv_refill",     32'(fetcher_completed), 32'h1);
        mem.mem_ack = 1'b0;

        // Timeout with TIMEOUT_CYCLES=4
        fetcher_reset = 1'b1;
        step();
        fetcher_reset = 1'b0;
        pc            = 32'h300;
        step();
        check("to_addr", 32'(mem.mem_addr), 32'hC0);
        check("to_req0", 32'(mem.mem_req),  32'h1);
        for (int i = 1; i < 4; i++) begin
            step();
            check("to_req_high", 32'(mem.mem_req), 32'h1);
        end
        step();
        check("to_retry_req",  32'(mem.mem_req),       32'h0);
        check("to_count",      32'(timeout_count),     32'h1);
        check("to_retry_done", 32'(fetcher_completed), 32'h0);
        step();
        check("to_reissue",    32'(mem.mem_req),       32'h1);
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'h1234_5678;
        step();
        check("to_done",       32'(fetcher_completed), 32'h1);
        check("to_instr",      instruction,            32'h1234_5678);
        check("to_count_keep", 32'(timeout_count),     32'h1);
        mem.mem_ack = 1'b0;

        // Abort: fetcher_reset together with ack
        fetcher_reset = 1'b1;
        step();
        fetcher_reset = 1'b0;
        pc            = 32'h400;
        step();
        check("ab_req", 32'(mem.mem_req), 32'h1);
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hDEAD_BEEF;
        fetcher_reset = 1'b1;
        step();
        mem.mem_ack = 1'b0;
        check("ab_done",   32'(fetcher_completed), 32'h0);
        check("ab_instr",  instruction,            32'h1234_5678);
        check("ab_req0",   32'(mem.mem_req),       32'h0);
        step();
        check("ab_done2",  32'(fetcher_completed), 32'h0);
        fetcher_reset = 1'b0;
        step();
        check("ab_remiss",      32'(mem.mem_req),  32'h1);
        check("ab_remiss_addr", 32'(mem.mem_addr), 32'h100);

        // Reset mid-REQ, also overriding a concurrent ack
        reset         = 1'b1;
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hDEAD_BEEF;
        step();
        mem.mem_ack = 1'b0;
        check("mr_req",      32'(mem.mem_req),       32'h0);
        check("mr_instr",    instruction,            32'h0);
        check("mr_timeouts", 32'(timeout_count),     32'h0);
        check("mr_done",     32'(fetcher_completed), 32'h0);
        reset = 1'b0;
        pc    = 32'h300;
        step();
        check("mr_miss",      32'(mem.mem_req),  32'h1);
        check("mr_miss_addr", 32'(mem.mem_addr), 32'hC0);

        // Address wrap plus invalidate coinciding with a fill
        fetcher_reset = 1'b1;
        step();
        fetcher_reset = 1'b0;
        pc            = 32'hFFFF_FFFC;
        step();
        check("wrap_addr", 32'(mem.mem_addr), 32'h3FFF_FFFF);
        check("wrap_req",  32'(mem.mem_req),  32'h1);
        mem.mem_ack   = 1'b1;
        mem.mem_rdata = 32'hCAFE_F00D;
        cache_inv     = 1'b1;
        step();
        mem.mem_ack = 1'b0;
        cache_inv   = 1'b0;
        check("fillinv_done",  32'(fetcher_completed), 32'h1);
        check("fillinv_instr", instruction,            32'hCAFE_F00D);
        fetcher_reset = 1'b1;
        step();
        fetcher_reset = 1'b0;
        step();
        check("fillinv_miss", 32'(mem.mem_req),       32'h1);
        check("fillinv_nd",   32'(fetcher_completed), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
